// File: rtl/delta_extractor.sv
// Recovers the signed step between consecutive samples of a modular counter.
// Emits magnitude/direction per sample pair through a single-entry output register.
module delta_extractor #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_DELTA = 2 ** (WIDTH - 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] value_i,
  input  logic             wrap_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] delta_o,
  output logic             down_o,
  output logic             error_o
);

  typedef enum logic {
    EMPTY,
    ARMED
  } state_t;

  localparam logic [WIDTH-1:0] Half = WIDTH'(1) << (WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] step_delta;
  logic             step_down;
  logic             step_err;
  logic             push;
  logic             pop;

  assign push = valid_i && ready_o;
  assign pop  = valid_o && ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = EMPTY;
    end else if (push) begin
      state_d = ARMED;
    end
  end

  // ready stays low through reset; clear blocks consumption outright
  always_comb begin
    ready_o = rst_ni && !clear_i && (state_q == EMPTY || !valid_o || ready_i);
  end

  // Shortest modular path wins; the exact half-range step counts as upward.
  always_comb begin
    diff       = value_i - prev_q;
    step_down  = 1'b0;
    step_delta = diff;
    if (diff > Half) begin
      step_down  = 1'b1;
      step_delta = '0 - diff;
    end
    step_err = wrap_i || (state_q == ARMED && 32'(step_delta) > MAX_DELTA);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prev_q  <= '0;
      valid_o <= 1'b0;
      delta_o <= '0;
      down_o  <= 1'b0;
      error_o <= 1'b0;
    end else if (clear_i) begin
      prev_q  <= '0;
      valid_o <= 1'b0;
      delta_o <= '0;
      down_o  <= 1'b0;
      error_o <= 1'b0;
    end else if (push) begin
      prev_q <= value_i;
      if (step_err) begin
        error_o <= 1'b1;
      end
      if (state_q == ARMED) begin
        valid_o <= 1'b1;
        delta_o <= step_delta;
        down_o  <= step_down;
      end
    end else if (pop) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_delta_extractor.sv
// Randomized and directed checks of delta_extractor against a cycle-level
// reference that derives each step as the shorter way round the counter ring.
module tb_delta_extractor;

  localparam int W    = 4;
  localparam int MAXD = 4;
  localparam int MOD  = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clear;
  logic         sample_valid;
  logic         sample_ready;
  logic [W-1:0] value;
  logic         wrap;
  logic         beat_valid;
  logic         beat_ready;
  logic [W-1:0] delta;
  logic         down;
  logic         error;

  int checks   = 0;
  int failures = 0;

  // reference state
  logic m_armed, m_valid, m_down, m_err, m_zero;
  int   m_prev, m_delta;

  always #5 clk = ~clk;

  delta_extractor #(
    .WIDTH    (W),
    .MAX_DELTA(MAXD)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clear_i(clear),
    .valid_i(sample_valid),
    .ready_o(sample_ready),
    .value_i(value),
    .wrap_i (wrap),
    .valid_o(beat_valid),
    .ready_i(beat_ready),
    .delta_o(delta),
    .down_o (down),
    .error_o(error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_armed = 1'b0; m_valid = 1'b0; m_down = 1'b0; m_err = 1'b0;
    m_zero  = 1'b1; m_prev  = 0;    m_delta = 0;
  endtask

  // one clock: drive, compare outputs against the reference, then advance it
  task automatic step(input logic r, input logic c, input logic v, input int val,
                      input logic w, input logic rd);
    logic exp_rdy;
    int   up, dn;
    @(negedge clk);
    rst_n = r; clear = c; sample_valid = v; value = W'(val); wrap = w; beat_ready = rd;
    #1;
    exp_rdy = r && !c && (!m_armed || !m_valid || rd);
    check("ready", {31'b0, sample_ready}, {31'b0, exp_rdy});
    check("valid", {31'b0, beat_valid}, {31'b0, m_valid});
    check("error", {31'b0, error}, {31'b0, m_err});
    if (m_valid || m_zero) begin
      check("delta", {28'b0, delta}, m_delta);
      check("down", {31'b0, down}, {31'b0, m_down});
    end
    @(posedge clk);
    if (!r) begin
      model_reset();
    end else if (c) begin
      m_armed = 1'b0; m_valid = 1'b0; m_err = 1'b0; m_zero = 1'b0;
    end else if (v && exp_rdy) begin
      if (w) m_err = 1'b1;
      if (m_armed) begin
        up = (val % MOD + MOD - m_prev) % MOD;
        dn = (m_prev + MOD - val % MOD) % MOD;
        if (up <= dn) begin m_delta = up; m_down = 1'b0; end
        else          begin m_delta = dn; m_down = 1'b1; end
        if (m_delta > MAXD) m_err = 1'b1;
        m_valid = 1'b1;
      end
      m_prev  = val % MOD;
      m_armed = 1'b1;
    end else if (m_valid && rd) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic feed(input int val, input logic w);
    step(1'b1, 1'b0, 1'b1, val, w, 1'b1);
  endtask

  task automatic idle(input logic rd);
    step(1'b1, 1'b0, 1'b0, 0, 1'b0, rd);
  endtask

  task automatic do_clear();
    step(1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b1);
  endtask

  // absolute expectation from the documented scenarios, sampled just after the edge
  task automatic expect_beat(input string tag, input int d, input logic dn);
    logic [3:0] dv;
    dv = W'(d);
    #1;
    check({tag, "_v"}, {31'b0, beat_valid}, 32'd1);
    check(tag, {27'b0, delta, down}, {27'b0, dv, dn});
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; sample_valid = 1'b0; value = '0; wrap = 1'b0; beat_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    step(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 5, 1'b0, 1'b1);

    // basic up/down steps
    feed(3, 1'b0);
    feed(7, 1'b0);  expect_beat("tp_up", 4, 1'b0);
    feed(5, 1'b0);  expect_beat("tp_down", 2, 1'b1);
    idle(1'b1);

    // wrap-around in both directions
    do_clear();
    feed(14, 1'b0);
    feed(1, 1'b0);  expect_beat("wrap_up", 3, 1'b0);
    feed(15, 1'b0); expect_beat("wrap_down", 2, 1'b1);
    check("wrap_err", {31'b0, error}, 32'd0);
    idle(1'b1);

    // tie rule and limit
    do_clear();
    feed(0, 1'b0);
    feed(8, 1'b0);  expect_beat("tie", 8, 1'b0);
    check("tie_err", {31'b0, error}, 32'd1);
    feed(13, 1'b0); expect_beat("after_tie", 5, 1'b0);
    check("err_sticky", {31'b0, error}, 32'd1);
    idle(1'b1);
    idle(1'b1);

    // backpressure then simultaneous pop/push
    do_clear();
    feed(2, 1'b0);
    feed(5, 1'b0);  expect_beat("bp_first", 3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b1, 9, 1'b0, 1'b0);
      expect_beat("bp_hold", 3, 1'b0);
    end
    step(1'b1, 1'b0, 1'b1, 9, 1'b0, 1'b1); expect_beat("bp_release", 4, 1'b0);
    idle(1'b1);

    // producer overflow flag on the second sample
    do_clear();
    feed(4, 1'b0);
    feed(6, 1'b1);  expect_beat("wrapflag", 2, 1'b0);
    check("wrapflag_err", {31'b0, error}, 32'd1);

    // clear with a live sample and a pending beat
    step(1'b1, 1'b1, 1'b1, 9, 1'b0, 1'b0);
    #1;
    check("clr_valid", {31'b0, beat_valid}, 32'd0);
    check("clr_err", {31'b0, error}, 32'd0);
    feed(9, 1'b0);
    feed(6, 1'b0);  expect_beat("clr_after", 3, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // reset while a beat is stalled
    do_clear();
    feed(1, 1'b0);
    feed(3, 1'b0);
    step(1'b1, 1'b0, 1'b1, 7, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    #1;
    check("rst_valid", {31'b0, beat_valid}, 32'd0);
    check("rst_delta", {28'b0, delta}, 32'd0);
    feed(10, 1'b0);
    idle(1'b1);
    feed(12, 1'b0); expect_beat("rst_rearm", 2, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int   v;
      logic r, c, w, vl, rd;
      r  = ($urandom_range(0, 199) != 0);
      c  = ($urandom_range(0, 39) == 0);
      vl = ($urandom_range(0, 9) < 7);
      w  = ($urandom_range(0, 29) == 0);
      rd = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 3) == 0) v = int'($urandom_range(0, MOD - 1));
      else v = (m_prev + MOD + int'($urandom_range(0, 6)) - 3) % MOD;
      step(r, c, vl, v, w, rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/delta_extractor.md
# delta_extractor

Differentiating companion to the up/down delta counter: consumes a stream of sampled counter values and emits, per pair of consecutive samples, the magnitude and direction of the step between them. It recovers the `delta`/`down` pair that produced each counter update, including across modular wrap-around. It sits on the monitoring side of a counter, for example in a performance-counter readout or credit tracker, with valid/ready handshakes on both sides.

## Interface
- `WIDTH`, default 4: width of sampled values and of emitted deltas.
- `MAX_DELTA`, default 2^(WIDTH-1): largest legal step magnitude. A larger step flags an error.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, synchronous and active-low.
- `clear_i`  in  1  synchronous clear: drop reference sample, flush output, clear error.
- `valid_i`  in  1  input sample valid.
- `ready_o`  out  1  input sample accepted when `valid_i && ready_o`.
- `value_i`  in  WIDTH  sampled counter value.
- `wrap_i`  in  1  producer's overflow flag accompanying `value_i`.
- `valid_o`  out  1  delta output valid.
- `ready_i`  in  1  downstream accepts the delta.
- `delta_o`  out  WIDTH  step magnitude.
- `down_o`  out  1  step direction: 1 means value decreased.
- `error_o`  out  1  sticky error flag.

## Operation
- FSM states:
  - `EMPTY`: no reference sample held.
  - `ARMED`: reference `prev_q` held.
- Transitions:
  - `EMPTY`, on handshake: `prev_q <= value_i`, go to `ARMED`. No output is produced for the first sample.
  - `ARMED`, on handshake: compute the step, load the output register, update `prev_q <= value_i`, stay in `ARMED`.
  - Any state, on `clear_i`: go to `EMPTY`.
- Step arithmetic, all modulo 2^WIDTH:
  - `diff = value_i - prev_q`, truncated to WIDTH bits.
  - If `diff < 2^(WIDTH-1)`: `down_o = 0`, `delta_o = diff`.
  - If `diff == 2^(WIDTH-1)`: same as above, direction up (tie rule).
  - If `diff > 2^(WIDTH-1)`: `down_o = 1`, `delta_o = 2^WIDTH - diff`.
- Zero step (`value_i == prev_q`) emits `delta_o = 0`, `down_o = 0`. It is still a valid output beat.
- `error_o` sets on an accepted sample in `ARMED` when either condition holds:
  - `wrap_i` = 1, or
  - the computed `delta_o > MAX_DELTA`.
- The offending delta is still emitted.
- `error_o` is cleared only by reset or `clear_i`.
- A sample accepted in `EMPTY` with `wrap_i` = 1 also sets `error_o`.
- Output register is single-entry:
  - `ready_o = !clear_i && (state == EMPTY || !valid_o || ready_i)`.
  - While `valid_o && !ready_i`, `delta_o` and `down_o` hold stable.
- Simultaneous events:
  - `clear_i` has priority over any handshake. With `clear_i` = 1, `ready_o` is 0, the sample is not consumed, and the pending output is discarded.
  - Output pop and new input push in the same cycle: the output register reloads with the new delta, and `valid_o` stays 1.
  - Output pop without a push in `ARMED`: `valid_o` falls to 0 next cycle.

## Timing
- All state updates occur on rising `clk_i`. Reset is sampled synchronously.
- Reset values while `rst_ni` is low, and after release:

  | Signal / state | Value |
  |---|---|
  | `valid_o` | 0 |
  | `delta_o` | 0 |
  | `down_o` | 0 |
  | `error_o` | 0 |
  | FSM state | `EMPTY` |
  | `prev_q` | 0 |
  | `ready_o` | 0 while `rst_ni` low; 1 in the first cycle after release |

- Latency: a sample accepted in cycle N (in `ARMED`) gives `valid_o` = 1 with its delta in cycle N+1.
- Throughput: one delta per cycle when `ready_i` is held at 1.
- Combinational paths: `ready_i -> ready_o` is combinational. There is no path from `valid_i` to `valid_o`.
- `clear_i` in cycle N:
  - `valid_o` = 0, state `EMPTY`, and `error_o` = 0 in cycle N+1.
  - The first sample after the clear only re-arms the reference.
- Reset mid-transfer: the pending output is lost and the reference is discarded. No output beat appears after reset until two new samples have been accepted.

## Test plan
- WIDTH=4, `ready_i`=1. Feed samples 3, 7, 5.
  - Sample 3 produces no output.
  - Expect `{delta_o, down_o}` = {4, 0}, then {2, 1}, each one cycle after its input handshake.
- Wrap-around. Feed 14, 1, 15.
  - Expect {3, 0} (14→1 via wrap), then {2, 1}.
  - `error_o` stays 0.
- Tie and limit, WIDTH=4, MAX_DELTA=4. Feed 0, 8, 13.
  - Expect {8, 0} (tie rule, up) with `error_o` rising.
  - Then {5, 0}. `error_o` remains 1 until `clear_i`.
- Backpressure. Hold `ready_i` = 0 after the first delta.
  - `valid_o` and `delta_o` stay stable.
  - `ready_o` = 0 and further `valid_i` beats are not consumed.
  - Release `ready_i` = 1 and the pop/push happens in the same cycle with no beat lost.
- Feed `wrap_i` = 1 on the second sample: the delta is emitted and `error_o` = 1.
- `clear_i` together with `valid_i`.
  - The sample is not consumed, `valid_o` = 0 next cycle, `error_o` = 0.
  - Feeding 9 then 6 afterwards yields only {3, 1}.
- Assert `rst_ni` = 0 while `valid_o` = 1 and `ready_i` = 0.
  - All outputs return to 0 on the next edge.
  - The next two samples re-arm, then produce exactly one delta.
